// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake and scan outputs of the 8-digit 7-segment scan controller.
// slave is the controller side, master the content source / display side.
interface seg7_scan_ctrl_if;
    logic        load_req;
    logic [31:0] load_data;
    logic [7:0]  load_dp;
    logic [7:0]  load_blank;
    logic        load_ack;
    logic [2:0]  digit_sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_start;

    modport slave (
        input  load_req, load_data, load_dp, load_blank,
        output load_ack, digit_sel, seg_n, dp_n, frame_start
    );

    modport master (
        output load_req, load_data, load_dp, load_blank,
        input  load_ack, digit_sel, seg_n, dp_n, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 8-digit common-anode scan driver; segments registered in step with digit_sel, loads applied at frame wrap (ack 1 cycle after).
// No backpressure: load_req always accepted, last wins; SEG7_LEADING_ZERO_BLANK_EN adds leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] presc;
    logic [2:0]       digit_sel_q;
    logic [31:0]      stg_data, shd_data;
    logic [7:0]       stg_dp, shd_dp;
    logic [7:0]       stg_blank, shd_blank;
    logic             pending;
    logic             load_ack_q;
    logic             frame_start_q;
    logic [6:0]       seg_n_q;
    logic             dp_n_q;

    logic             tick;
    logic             wrap;
    logic             apply;
    logic [2:0]       nxt_digit;
    logic [31:0]      nxt_data;
    logic [7:0]       nxt_dp;
    logic [7:0]       nxt_blank;
    logic [7:0]       nxt_mask;
    logic [3:0]       nxt_nib;
    logic [6:0]       nxt_seg_n;
    logic             nxt_dp_n;

    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick  = (presc == PRESC_LAST);
    assign wrap  = tick && (digit_sel_q == 3'd7);
    assign apply = wrap && pending;

    // Outputs are computed from the post-edge digit and shadow so they move with digit_sel
    always_comb begin
        nxt_digit = tick ? digit_sel_q + 3'd1 : digit_sel_q;
        nxt_data  = apply ? stg_data  : shd_data;
        nxt_dp    = apply ? stg_dp    : shd_dp;
        nxt_blank = apply ? stg_blank : shd_blank;
    end

    always_comb begin : mask_calc
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        logic above;
        above    = 1'b1;
        nxt_mask = nxt_blank;
        // Walk down from the top digit; a digit stays dark while everything above it is dark or zero
        for (int i = 7; i >= 1; i--) begin
            if ((nxt_data[4*i +: 4] == 4'h0) && !nxt_dp[i] && above)
                nxt_mask[i] = 1'b1;
            above = above && ((nxt_data[4*i +: 4] == 4'h0) || nxt_mask[i]);
        end
`else
        nxt_mask = nxt_blank;
`endif
    end

    always_comb begin
        nxt_nib   = nxt_data[{nxt_digit, 2'b00} +: 4];
        nxt_seg_n = 7'h7F;
        nxt_dp_n  = 1'b1;
        if (!nxt_mask[nxt_digit]) begin
            nxt_seg_n = hex2seg(nxt_nib);
            nxt_dp_n  = ~nxt_dp[nxt_digit];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc         <= '0;
            digit_sel_q   <= 3'd0;
            stg_data      <= 32'h0;
            stg_dp        <= 8'h00;
            stg_blank     <= 8'hFF;
            shd_data      <= 32'h0;
            shd_dp        <= 8'h00;
            shd_blank     <= 8'hFF;
            pending       <= 1'b0;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            seg_n_q       <= 7'h7F;
            dp_n_q        <= 1'b1;
        end else begin
            presc         <= tick ? '0 : presc + 1'b1;
            digit_sel_q   <= nxt_digit;
            load_ack_q    <= apply;
            frame_start_q <= wrap;
            seg_n_q       <= nxt_seg_n;
            dp_n_q        <= nxt_dp_n;
            if (apply) begin
                shd_data  <= stg_data;
                shd_dp    <= stg_dp;
                shd_blank <= stg_blank;
            end
            // A new request wins over the apply clearing pending; it waits for the next wrap
            if (bus.load_req) begin
                stg_data  <= bus.load_data;
                stg_dp    <= bus.load_dp;
                stg_blank <= bus.load_blank;
                pending   <= 1'b1;
            end else if (apply) begin
                pending   <= 1'b0;
            end
        end
    end

    assign bus.load_ack    = load_ack_q;
    assign bus.frame_start = frame_start_q;
    assign bus.digit_sel   = digit_sel_q;
    assign bus.seg_n       = seg_n_q;
    assign bus.dp_n        = dp_n_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed driver for an 8-digit common-anode 7-segment display.
- Sits directly upstream of the 3-to-8 active-low digit decoder: produces the 3-bit digit index that the decoder turns into active-low anode enables.
- Also produces the matching active-low segment and decimal-point levels.
- Display content is loaded through a req/ack handshake and applied only at frame boundaries, so no frame shows mixed old and new digits.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot (≥2); the prescaler counts 0..SCAN_DIV-1.
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- load_req  in  1  one-cycle strobe; samples load_data/load_dp/load_blank
- load_data  in  32  8 hex digits; digit i = load_data[4i+3:4i]
- load_dp  in  8  decimal point per digit, 1 = lit
- load_blank  in  8  per-digit blank, 1 = digit fully dark
- load_ack  out  1  one-cycle pulse when staged content becomes visible
- digit_sel  out  3  current digit index, to the digit decoder
- seg_n  out  7  {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse when digit_sel wraps 7→0

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - prescaler=0, digit_sel=0
  - staging and shadow data=0, dp=0, blank=8'hFF
  - pending=0, load_ack=0, frame_start=0
  - seg_n=7'h7F, dp_n=1
- Reset asserted mid-scan or mid-load discards any pending load; no ack is produced.
- Prescaler:
  - Increments every cycle.
  - tick = (prescaler==SCAN_DIV-1). On tick the prescaler returns to 0 and digit_sel increments modulo 8.
- Load capture:
  - load_req=1 copies the inputs into staging and sets pending.
  - A load_req while pending=1 overwrites staging (last wins). Only one ack follows.
- Apply:
  - Happens on the tick where digit_sel goes 7→0 with pending=1 (the pending value registered before this edge).
  - On that edge: shadow←staging, pending←0, load_ack=1 for exactly that following cycle.
  - A load_req in the same cycle as the wrap tick is staged, not applied. It is applied at the next wrap; pending stays 1.
  - A load_req in the same cycle as an apply re-sets pending with the new content.
- frame_start is 1 for the one cycle after the 7→0 edge, coincident with load_ack when an apply occurs.
- Output timing:
  - seg_n and dp_n are registered and computed from the next digit index and next shadow.
  - They change on the same edge as digit_sel, giving zero skew against the decoder input.
- Segment encoding (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Blanking: a blanked digit forces seg_n=7F and dp_n=1. Otherwise dp_n=~shadow_dp[digit_sel].
- No other outputs change between ticks.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: a digit is also blanked if its nibble is 0, every higher-index digit is 0 or blanked, its index is not 0, and its dp bit is 0. Digit 0 always shows.
  - Example: 32'h0000_00A5 shows only digits 1 and 0.
- When undefined: only load_blank blanks a digit; all zeros are displayed.
- Blanking is evaluated on shadow contents, so the handshake is unchanged either way.

Test Plan:
- Reset, SCAN_DIV=4: hold rst_n=0 for 3 cycles, then release.
  - Required: digit_sel=0, seg_n=7F, dp_n=1, load_ack=0.
  - digit_sel steps 0,1,…,7,0 every 4 cycles; frame_start pulses once per 32 cycles.
- Load: load_req with data=32'h89AB_CDEF, dp=8'h01, blank=0 mid-frame.
  - Required: no visible change until the wrap; load_ack pulses together with frame_start.
  - Then digit 0 shows seg_n=0E with dp_n=0, digit 7 shows 00, digit 4 shows 03.
- Back-to-back loads: load_req with data=1111_1111 then data=2222_2222 within the same frame.
  - Required: a single load_ack; all digits show 24.
- Wrap collision: load_req in the same cycle as the digit 7→0 tick.
  - Required: no ack at that wrap; ack and new content one frame (8·SCAN_DIV cycles) later.
- Blanking and reset mid-load:
  - blank=8'hF0 → digits 7–4 give seg_n=7F, dp_n=1.
  - Assert rst_n=0 while pending=1 → no load_ack ever appears and the display stays blank.
- SEG7_LEADING_ZERO_BLANK_EN, data=32'h0000_00A5:
  - Defined: digits 7–2 show 7F, digit 1 shows 08, digit 0 shows 12.
  - Undefined: digits 7–2 show 40.
